// File: rtl/handshake_elastic_fifo_pkg.sv
// ----------------------------------------------------------------------------
// handshake_elastic_fifo_pkg
//   Shared constants and sizing helpers for the elastic handshake FIFO.
//   The helpers give the pointer and occupancy-counter widths that belong to a
//   given storage depth, so the top and the pointer sub-module always agree.
// ----------------------------------------------------------------------------
package handshake_elastic_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_NUM_SLOTS  = 4;

  // A pointer must be at least one bit wide, even for the smallest depths.
  function automatic int ptr_width(input int num_slots);
    return ($clog2(num_slots) < 1) ? 1 : $clog2(num_slots);
  endfunction

  // The counter has to represent every value from 0 up to and including
  // num_slots, hence the +1.
  function automatic int count_width(input int num_slots);
    return $clog2(num_slots + 1);
  endfunction

endpackage

// File: rtl/handshake_elastic_fifo_if.sv
// ----------------------------------------------------------------------------
// handshake_elastic_fifo_if
//   Bundles the upstream and downstream valid/ready links of the elastic FIFO.
//   Ports:
//     ins, ins_valid, ins_ready      upstream payload / token present / accept
//     outs, outs_valid, outs_ready   head payload / head valid / downstream accept
//   Modports:
//     slave   the FIFO side (takes ins/ins_valid/outs_ready, drives the rest)
//     master  the surrounding fabric or bench (the mirror image)
// ----------------------------------------------------------------------------
interface handshake_elastic_fifo_if
  import handshake_elastic_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] ins;
  logic                  ins_valid;
  logic                  ins_ready;
  logic [DATA_WIDTH-1:0] outs;
  logic                  outs_valid;
  logic                  outs_ready;

  modport slave (
    input  ins,
    input  ins_valid,
    input  outs_ready,
    output ins_ready,
    output outs,
    output outs_valid
  );

  modport master (
    output ins,
    output ins_valid,
    output outs_ready,
    input  ins_ready,
    input  outs,
    input  outs_valid
  );

endinterface

// File: rtl/handshake_elastic_fifo_ptr.sv
// ----------------------------------------------------------------------------
// handshake_fifo_ptr
//   Modulo-NUM_SLOTS wrapping pointer with an advance enable.  Used for both
//   the head (read) and tail (write) pointers of the elastic FIFO.
//   Ports:
//     clk  clock, rising edge
//     rst  asynchronous active-high reset, returns the pointer to slot 0
//     en   advance the pointer by one slot on this edge
//     ptr  current slot index, 0 .. NUM_SLOTS-1
// ----------------------------------------------------------------------------
module handshake_fifo_ptr
  import handshake_elastic_fifo_pkg::*;
#(
  parameter int NUM_SLOTS = DEFAULT_NUM_SLOTS,
  parameter int PTR_W     = ptr_width(NUM_SLOTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(NUM_SLOTS - 1);

  // Explicit wrap at the last slot: for non-power-of-two depths the natural
  // binary rollover would walk into slots that do not exist.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      if (ptr == LAST_SLOT) begin
        ptr <= '0;
      end else begin
        ptr <= ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/handshake_elastic_fifo.sv
// ----------------------------------------------------------------------------
// handshake_elastic_fifo
//   Elastic FIFO for the dataflow handshake fabric.  Cuts the combinational
//   valid and ready paths between producer and consumer and absorbs consumer
//   stalls without losing tokens.  All outputs come from registered state, and
//   a token accepted on one edge is visible at the output after that edge.
//   Ports:
//     clk  clock, all state updates on the rising edge
//     rst  asynchronous active-high reset (empties the buffer, clears storage)
//     bus  handshake_elastic_fifo_if.slave:
//          ins/ins_valid/ins_ready       upstream link
//          outs/outs_valid/outs_ready    downstream link
// ----------------------------------------------------------------------------
module handshake_elastic_fifo
  import handshake_elastic_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_SLOTS  = DEFAULT_NUM_SLOTS
) (
  input logic                    clk,
  input logic                    rst,
  handshake_elastic_fifo_if.slave bus
);

  localparam int PTR_W = ptr_width(NUM_SLOTS);
  localparam int CNT_W = count_width(NUM_SLOTS);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(NUM_SLOTS);

  logic [DATA_WIDTH-1:0] storage [NUM_SLOTS];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;
  logic                  push;
  logic                  pop;

  // Both handshake outputs are decoded from the occupancy counter only, so
  // there is no combinational path from outs_ready to ins_ready, nor from the
  // upstream side to outs/outs_valid.  A full buffer refuses input even when
  // the consumer is popping in the same cycle; that keeps ready registered.
  assign bus.ins_ready  = (count != FULL_COUNT);
  assign bus.outs_valid = (count != '0);
  assign bus.outs       = storage[head];

  assign push = bus.ins_valid  & bus.ins_ready;
  assign pop  = bus.outs_valid & bus.outs_ready;

  handshake_fifo_ptr #(
    .NUM_SLOTS (NUM_SLOTS),
    .PTR_W     (PTR_W)
  ) u_head_ptr (
    .clk (clk),
    .rst (rst),
    .en  (pop),
    .ptr (head)
  );

  handshake_fifo_ptr #(
    .NUM_SLOTS (NUM_SLOTS),
    .PTR_W     (PTR_W)
  ) u_tail_ptr (
    .clk (clk),
    .rst (rst),
    .en  (push),
    .ptr (tail)
  );

  // Storage is cleared on reset so outs reads as zero while the buffer is
  // empty after reset.  A write can never land on the slot being read while
  // it is valid, because tail only equals head when the buffer is empty or
  // full, and a full buffer does not accept a push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        storage[i] <= '0;
      end
    end else if (push) begin
      storage[tail] <= bus.ins;
    end
  end

  // Occupancy: a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
